// File: rtl/rv_bfms_pkg.sv
// Shared types and helpers for the ready/valid BFM blocks.
// Holds the presentation FSM state type and the throttle LFSR step function.
package rv_bfms_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } rv_out_state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the 16-bit Fibonacci LFSR: shift left, feed back the tap parity.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {cur[14:0], fb};
  endfunction

endpackage

// File: rtl/rv_bfm_fifo.sv
// Show-ahead FIFO used by the ready/valid source BFM.
// head_o is the oldest word, next_o the one behind it; both are valid
// whenever the occupancy covers them. Pointers wrap naturally (DEPTH is a
// power of two). Push on full and pop on empty are ignored.
module rv_bfm_fifo
  import rv_bfms_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [DATA_WIDTH-1:0] next_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [CNT_W-1:0]      count_next_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_inc_s;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign push_ok_s    = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok_s     = pop_i && (count_q != CNT_W'(0));
  assign rd_ptr_inc_s = rd_ptr_q + PTR_W'(1);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_inc_s;
      count_q <= count_d;
    end
  end

  // Storage array; cleared on reset so no stale word can ever be shown.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign next_o       = mem_q[rd_ptr_inc_s];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/rv_data_out_bfm.sv
// Ready/valid source stage: buffers host words and drives them downstream.
// Optional feature macro RV_DATA_OUT_THROTTLE_EN: an LFSR gates the launch
// of each new word to insert random idle cycles. Without it the gate is
// always open and the link streams at full rate.
// data_valid/data come straight from registers, so they never depend
// combinationally on data_ready.
module rv_data_out_bfm
  import rv_bfms_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
`ifdef RV_DATA_OUT_THROTTLE_EN
  ,
  parameter logic [15:0] IDLE_MASK = 16'h0003,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        req_data,
  input  logic                         req_valid,
  output logic                         req_ready,
  output logic [DATA_WIDTH-1:0]        data,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  rv_out_state_e         state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  req_ready_q;
  logic                  push_s;
  logic                  pop_s;
  logic                  gate_open_s;
  logic                  cand_valid_s;
  logic [DATA_WIDTH-1:0] cand_word_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [DATA_WIDTH-1:0] next_s;
  logic [CNT_W-1:0]      count_s;
  logic [CNT_W-1:0]      count_next_s;

  assign push_s = req_valid && req_ready_q;
  assign pop_s  = (state_q == ST_PRESENT) && data_ready;

  rv_bfm_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock_i      (clock),
    .reset_i      (reset),
    .push_i       (push_s),
    .wdata_i      (req_data),
    .pop_i        (pop_s),
    .head_o       (head_s),
    .next_o       (next_s),
    .count_o      (count_s),
    .count_next_o (count_next_s)
  );

`ifdef RV_DATA_OUT_THROTTLE_EN
  logic [15:0] lfsr_q;

  // Free-running LFSR that drives the launch gate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign gate_open_s = ((lfsr_q & IDLE_MASK) == 16'h0000);
`else
  assign gate_open_s = 1'b1;
`endif

  // Word that would be presented after this edge. A push into an empty
  // FIFO is bypassed so it shows one cycle after the push edge.
  always_comb begin
    cand_valid_s = 1'b0;
    cand_word_s  = data_q;
    if (state_q == ST_IDLE) begin
      cand_valid_s = (count_s != CNT_W'(0)) || push_s;
      if (count_s != CNT_W'(0)) cand_word_s = head_s;
      else                      cand_word_s = req_data;
    end else if (pop_s) begin
      cand_valid_s = (count_s > CNT_W'(1)) || push_s;
      if (count_s > CNT_W'(1)) cand_word_s = next_s;
      else                     cand_word_s = req_data;
    end else begin
      cand_valid_s = 1'b1;
      cand_word_s  = data_q;
    end
  end

  // Presentation FSM with registered data and req_ready outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      req_ready_q <= 1'b0;
    end else begin
      req_ready_q <= (count_next_s != CNT_W'(DEPTH));
      case (state_q)
        ST_IDLE: begin
          if (cand_valid_s && gate_open_s) begin
            state_q <= ST_PRESENT;
            data_q  <= cand_word_s;
          end
        end
        ST_PRESENT: begin
          if (pop_s) begin
            if (cand_valid_s && gate_open_s) data_q  <= cand_word_s;
            else                             state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign data       = data_q;
  assign data_valid = (state_q == ST_PRESENT);
  assign count      = count_s;

endmodule

// File: tb/tb_rv_data_out_bfm.sv
// Self-checking bench for rv_data_out_bfm: a queue-based model of the
// buffered link is checked against the DUT every cycle, plus literal
// expectations in the directed phases.
module tb_rv_data_out_bfm;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic [DW-1:0] req_data   = '0;
  logic          req_valid  = 1'b0;
  logic          data_ready = 1'b0;
  logic          req_ready;
  logic [DW-1:0] data;
  logic          data_valid;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  int gaps     = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_data;
  logic          exp_rdy;
  logic          vld_last  = 1'b0;
  logic [DW-1:0] data_last = '0;

  rv_data_out_bfm #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .count      (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else             n_pass++;
  endtask

  // Reference model: a bounded queue; the head is presented whenever the
  // queue is non-empty, a full queue refuses pushes, data holds when empty.
  initial begin
    logic push, vld, hs;
    exp_data = '0;
    exp_rdy  = 1'b0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        q.delete();
        exp_data = '0;
        exp_rdy  = 1'b0;
        vld_last = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
      end else begin
`ifdef RV_DATA_OUT_THROTTLE_EN
        vld = vld_last;
`else
        vld = (q.size() > 0);
`endif
        hs   = vld && data_ready;
        push = req_valid && exp_rdy;
        if (hs && q.size() > 0) void'(q.pop_front());
        if (push) q.push_back(req_data);
        if (q.size() > 0) exp_data = q[0];
        exp_rdy = (q.size() < DEPTH);
        #1;
        check("count", 32'(count), 32'(q.size()));
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
`ifdef RV_DATA_OUT_THROTTLE_EN
        if (data_valid) begin
          check("valid_nonempty", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) check("data", 32'(data), 32'(q[0]));
        end else if (q.size() > 0) begin
          gaps++;
        end
`else
        check("data_valid", 32'(data_valid), 32'(q.size() > 0));
        check("data", 32'(data), 32'(exp_data));
`endif
        if (vld_last && !hs) begin
          check("hold_valid", 32'(data_valid), 32'd1);
          check("hold_data", 32'(data), 32'(data_last));
        end
        vld_last  = data_valid;
        data_last = data;
      end
    end
  end

  // Empty the FIFO with a bounded wait.
  task automatic drain();
    req_valid  = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (count == '0 && !data_valid) break;
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(data_valid), 32'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    logic acc;

    // Reset and release
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // Three words streaming with data_ready=1
    data_ready = 1'b1;
    req_valid  = 1'b1;
    req_data   = 8'h11;
    @(negedge clock);
`ifndef RV_DATA_OUT_THROTTLE_EN
    check("first_valid", 32'(data_valid), 32'd1);
    check("first_data", 32'(data), 32'h11);
`endif
    req_data = 8'h22;
    @(negedge clock);
`ifndef RV_DATA_OUT_THROTTLE_EN
    check("second_data", 32'(data), 32'h22);
`endif
    req_data = 8'h33;
    @(negedge clock);
`ifndef RV_DATA_OUT_THROTTLE_EN
    check("third_data", 32'(data), 32'h33);
`endif
    req_valid = 1'b0;
    @(negedge clock);
`ifndef RV_DATA_OUT_THROTTLE_EN
    check("empty_valid", 32'(data_valid), 32'd0);
    check("empty_hold_data", 32'(data), 32'h33);
`endif
    drain();

    // Fill to full under back-pressure; fifth word is refused
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_data  = 8'hA0 + 8'(i);
      @(negedge clock);
      if (i == 3) check("full_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    check("full_count", 32'(count), 32'd4);
`ifndef RV_DATA_OUT_THROTTLE_EN
    check("full_valid", 32'(data_valid), 32'd1);
    check("full_data", 32'(data), 32'hA0);
`endif
    drain();
    check("drain_last_data", 32'(data), 32'hA3);

    // Occupancy 2, then simultaneous push and pop across pointer wrap
    data_ready = 1'b0;
    req_valid  = 1'b1;
    req_data   = 8'hB0;
    @(negedge clock);
    req_data = 8'hB1;
    @(negedge clock);
    check("two_count", 32'(count), 32'd2);
    data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_data = 8'hC0 + 8'(i);
      @(negedge clock);
`ifndef RV_DATA_OUT_THROTTLE_EN
      check("pushpop_count", 32'(count), 32'd2);
`endif
    end
`ifndef RV_DATA_OUT_THROTTLE_EN
    check("pushpop_head", 32'(data), 32'hC6);
`endif
    drain();

    // Reset while presenting with three words buffered
    data_ready = 1'b0;
    req_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data = 8'hD0 + 8'(i);
      @(negedge clock);
    end
    req_valid = 1'b0;
    check("pre_reset_count", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    check("async_valid", 32'(data_valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_data", 32'(data), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    req_valid  = 1'b1;
    req_data   = 8'h5A;
    data_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
`ifndef RV_DATA_OUT_THROTTLE_EN
    check("post_reset_valid", 32'(data_valid), 32'd1);
    check("post_reset_data", 32'(data), 32'h5A);
`endif
    drain();

    // 64 words with downstream always ready
    data_ready = 1'b1;
    sent = 0;
    cyc  = 0;
    while (sent < 64 && cyc < 2000) begin
      req_valid = 1'b1;
      req_data  = 8'(sent);
      acc       = req_ready;
      @(negedge clock);
      cyc++;
      if (acc) sent++;
    end
    check("stream_sent", 32'(sent), 32'd64);
    drain();
`ifdef RV_DATA_OUT_THROTTLE_EN
    check("throttle_gaps", 32'(gaps > 0), 32'd1);
`endif

    // Random traffic with toggling back-pressure
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_data   = 8'($urandom);
      data_ready = ($urandom_range(0, 3) != 0);
      if (req_valid && req_ready) sent++;
      @(negedge clock);
      cyc++;
    end
    check("random_sent", 32'(sent), 32'd1000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
